// File: rtl/gsx_pkg.sv
// Shared FSM encoding, filter constants and frame-geometry helper for the SGPIO frame sequencer.
package gsx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gsx_state_e;

  localparam int                 MATCH_W   = 4;
  localparam logic [MATCH_W-1:0] MATCH_MAX = 4'd15;

  function automatic int frame_bits(input int modules);
    return modules * 8;
  endfunction

endpackage

// File: rtl/gsx_rx_filter.sv
// Receive assembler and glitch filter: a frame is published only after MATCH_FRAMES identical
// consecutive frames, with a one-cycle update pulse when the published value changes.
module gsx_rx_filter
  import gsx_pkg::*;
#(
  parameter int N            = 24,
  parameter int MATCH_FRAMES = 2,
  localparam int KW          = $clog2(N)
) (
  input  logic          wSClock,
  input  logic          iReset,
  input  logic          i_sample,
  input  logic [KW-1:0] i_bit_idx,
  input  logic          i_bit,
  input  logic          i_frame_end,
  output logic [N-1:0]  o_data,
  output logic          o_update
);

  localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(MATCH_FRAMES);

  logic [N-2:0]       r_rx;
  logic [N-1:0]       r_cand;
  logic [N-1:0]       r_data;
  logic [MATCH_W-1:0] r_match;
  logic               r_update;

  logic [N-1:0]       w_frame;
  logic [N-1:0]       w_cand_next;
  logic [MATCH_W-1:0] w_match_next;
  logic               w_publish;

  // Bit N-1 arrives on the frame-end edge itself, so it is spliced in combinationally.
  assign w_frame = {i_bit, r_rx};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_cand_next  = r_cand;
    w_match_next = r_match;
    if (w_frame != r_cand) begin
      w_cand_next  = w_frame;
      w_match_next = MATCH_W'(1);
    end else if (r_match != MATCH_MAX) begin
      w_match_next = r_match + MATCH_W'(1);
    end
  end

  assign w_publish = i_frame_end && (w_match_next >= MATCH_TGT) && (w_cand_next != r_data);

  always_ff @(posedge wSClock) begin
    if (!iReset) begin
      r_rx     <= '0;
      r_cand   <= '0;
      r_data   <= '0;
      r_match  <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_publish;
      if (i_sample && !i_frame_end) r_rx[i_bit_idx] <= i_bit;
      if (i_frame_end) begin
        r_cand  <= w_cand_next;
        r_match <= w_match_next;
      end
      if (w_publish) r_data <= w_cand_next;
    end
  end

  assign o_data   = r_data;
  assign o_update = r_update;

endmodule

// File: rtl/gsx_frame_sequencer.sv
// SGPIO master frame sequencer: shifts fixed-length frames on wSClock, arbitrates the transmit
// vector between two requesters at frame boundaries and filters the received frames.
module gsx_frame_sequencer
  import gsx_pkg::*;
#(
  parameter int  TOTAL_OUTPUT_MODULES = 3,
  parameter int  MATCH_FRAMES         = 2,
  localparam int N                    = frame_bits(TOTAL_OUTPUT_MODULES)
) (
  input  logic         wSClock,
  input  logic         iReset,
  input  logic         iEnable,
  input  logic         iReqA,
  input  logic [N-1:0] ivDataA,
  output logic         oGntA,
  input  logic         iReqB,
  input  logic [N-1:0] ivDataB,
  output logic         oGntB,
  output logic         oSLoad,
  output logic         oSDataOut,
  input  logic         iSDataIn,
  output logic [N-1:0] ovDataIn,
  output logic         oInUpdate,
  output logic         oFrameDone,
  output logic         oBusy
);

  localparam int            KW     = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  gsx_state_e    r_state;
  gsx_state_e    w_state_next;
  logic [KW-1:0] r_k;
  logic [N-1:0]  r_shadow;
  logic          r_sload;
  logic          r_sdata;
  logic          r_gnt_a;
  logic          r_gnt_b;
  logic          r_rr_b;
  logic          r_tail;
  logic          r_frame_done;

  logic [KW-1:0] w_k_next;
  logic          w_sload_next;
  logic          w_sdata_next;
  logic          w_shifting;
  logic          w_last;
  logic          w_boundary;
  logic          w_tie;
  logic          w_pick_a;
  logic          w_pick_b;
  logic          w_rx_sample;
  logic [KW-1:0] w_rx_idx;

  assign w_shifting = (r_state != ST_IDLE);
  assign w_last     = (r_k == K_LAST);
  assign w_boundary = iEnable && ((r_state == ST_IDLE) || ((r_state == ST_RUN) && w_last));
  assign w_tie      = iReqA && iReqB;
  assign w_pick_a   = w_boundary && iReqA && (!iReqB || !r_rr_b);
  assign w_pick_b   = w_boundary && iReqB && (!iReqA || r_rr_b);

  // The pin shows bit k-1 while bit k is issued; r_tail flags bit N-1 still on the pin.
  assign w_rx_sample = (w_shifting && (r_k != '0)) || r_tail;
  assign w_rx_idx    = r_tail ? K_LAST : r_k - KW'(1);

  always_ff @(posedge wSClock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!iReset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (iEnable) w_state_next = ST_RUN;
      ST_RUN: begin
        if (!iEnable) w_state_next = w_last ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: if (w_last) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_k_next     = '0;
    w_sload_next = 1'b1;
    w_sdata_next = 1'b1;
    if (w_shifting) begin
      w_k_next     = w_last ? '0 : r_k + KW'(1);
      w_sload_next = w_last;
      w_sdata_next = r_shadow[r_k];
    end
  end

  always_ff @(posedge wSClock) begin
    if (!iReset) begin
      r_k          <= '0;
      r_shadow     <= '0;
      r_sload      <= 1'b1;
      r_sdata      <= 1'b1;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_rr_b       <= 1'b0;
      r_tail       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_k          <= w_k_next;
      r_sload      <= w_sload_next;
      r_sdata      <= w_sdata_next;
      r_gnt_a      <= w_pick_a;
      r_gnt_b      <= w_pick_b;
      r_tail       <= w_shifting && w_last;
      r_frame_done <= r_tail;
      if (w_pick_a)      r_shadow <= ivDataA;
      else if (w_pick_b) r_shadow <= ivDataB;
      // On a tie the pointer moves to the requester that lost.
      if (w_boundary && w_tie) r_rr_b <= w_pick_a;
    end
  end

  gsx_rx_filter #(
    .N            (N),
    .MATCH_FRAMES (MATCH_FRAMES)
  ) u_rx_filter (
    .wSClock     (wSClock),
    .iReset      (iReset),
    .i_sample    (w_rx_sample),
    .i_bit_idx   (w_rx_idx),
    .i_bit       (iSDataIn),
    .i_frame_end (r_tail),
    .o_data      (ovDataIn),
    .o_update    (oInUpdate)
  );

  assign oGntA      = r_gnt_a;
  assign oGntB      = r_gnt_b;
  assign oSLoad     = r_sload;
  assign oSDataOut  = r_sdata;
  assign oFrameDone = r_frame_done;
  assign oBusy      = w_shifting;

endmodule
